// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================
// mips_pkg : shared widths, store-buffer entry type, helpers
// Rev 1.0
// ============================================================
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_store_buffer_if.sv
`default_nettype none
// ============================================================
// mem_store_buffer_if : MEM-stage and data-memory signal bundle
// Rev 1.0
// ============================================================
interface mem_store_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              MemWriteM;
  logic              MemReadM;
  logic [ADDR_W-1:0] AddrM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ReadDataM;
  logic              StallM;
  logic              fence_req;
  logic              fence_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  MemWriteM, MemReadM, AddrM, WriteDataM, fence_req, mem_rdata,
    output ReadDataM, StallM, fence_ack, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MemWriteM, MemReadM, AddrM, WriteDataM, fence_req, mem_rdata,
    input  ReadDataM, StallM, fence_ack, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================
// sb_fwd_match : youngest-matching store selector for forwarding
// Rev 1.0
// ============================================================
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail_i - PTR_W'(k + 1);
      if (entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================
// mem_store_buffer : store FIFO that retires on free port cycles
// Rev 1.0
// ============================================================
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic               CLK,
  input  logic               rst,
  mem_store_buffer_if.slave  bus
);

  import mips_pkg::*;

  localparam int               PTR_W  = ptr_width(DEPTH);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  sb_entry_t         entries_q [DEPTH];
  sb_entry_t         entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              empty;
  logic              fence_hold;
  logic              wr_eff;
  logic              rd_eff;
  logic              port_busy;
  logic              drain;
  logic              enq;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full       = (count_q == C_FULL);
  assign empty      = (count_q == '0);
  // An outstanding fence masks the pipeline so the port is free every cycle.
  assign fence_hold = bus.fence_req & ~empty;
  assign wr_eff     = bus.MemWriteM & ~fence_hold;
  assign rd_eff     = bus.MemReadM & ~fence_hold;
  assign port_busy  = rd_eff | (wr_eff & ~full);
  assign drain      = ~empty & ~port_busy;
  assign enq        = wr_eff & ~full;

  assign bus.StallM    = fence_hold | (wr_eff & full);
  assign bus.fence_ack = empty;
  assign bus.mem_we    = drain;
  assign bus.mem_addr  = drain ? entries_q[head_q].addr : bus.AddrM;
  assign bus.mem_wdata = entries_q[head_q].data;
  assign bus.ReadDataM = fwd_hit ? fwd_data : bus.mem_rdata;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries_i (entries_q),
    .tail_i    (tail_q),
    .addr_i    (bus.AddrM),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_W'(1);
      count_d                 = count_q - CNT_W'(1);
    end else if (enq) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: bus.AddrM, data: bus.WriteDataM};
      tail_d            = tail_q + PTR_W'(1);
      count_d           = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================
// tb_mem_store_buffer : scenario bench with queue reference model
// Rev 1.0
// ============================================================
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic rst = 1'b0;
  always #5 CLK = ~CLK;

  mem_store_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_store_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: asynchronous read, synchronous write, self-clearing on reset.
  logic [31:0] mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];
  always @(posedge CLK) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 5) ? 32'hAAAA_0000 : (32'hD0D0_0000 | 32'(i));
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  st_t         q[$];
  logic [31:0] ref_mem [16];
  logic        e_we, e_stall, e_ack, e_chk_rd;
  logic [31:0] e_addr, e_wdata, e_rdata;
  int          act;
  int          errs = 0;
  int          checks = 0;

  task automatic model_expect();
    e_ack    = (q.size() == 0);
    e_we     = 1'b0;
    e_stall  = 1'b0;
    e_chk_rd = 1'b0;
    e_addr   = bus.AddrM;
    e_wdata  = 32'h0;
    e_rdata  = 32'h0;
    act      = 0;
    if (bus.fence_req && q.size() > 0) begin
      e_stall = 1'b1;
      act     = 1;
    end else if (bus.MemReadM) begin
      e_chk_rd = 1'b1;
      e_rdata  = ref_mem[bus.AddrM[3:0]];
      foreach (q[i]) if (q[i].a == bus.AddrM) e_rdata = q[i].d;
    end else if (bus.MemWriteM) begin
      if (q.size() < DEPTH) act = 2;
      else begin
        e_stall = 1'b1;
        act     = 1;
      end
    end else if (q.size() > 0) begin
      act = 1;
    end
    if (act == 1) begin
      e_we    = 1'b1;
      e_addr  = q[0].a;
      e_wdata = q[0].d;
    end
  endtask

  task automatic model_commit();
    if (act == 1) begin
      ref_mem[q[0].a[3:0]] = q[0].d;
      q.delete(0);
    end else if (act == 2) begin
      q.push_back('{a: bus.AddrM, d: bus.WriteDataM});
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic f);
    bus.MemWriteM  = wr;
    bus.MemReadM   = rd;
    bus.AddrM      = a;
    bus.WriteDataM = d;
    bus.fence_req  = f;
    @(negedge CLK);
    model_expect();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL rst_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.fence_ack !== 1'b1) begin errs++; $display("FAIL rst_ack got=%b exp=1", bus.fence_ack); end
    checks++; if (bus.StallM !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", bus.StallM); end
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
    checks++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL idle_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.fence_ack !== 1'b1) begin errs++; $display("FAIL idle_ack got=%b exp=1", bus.fence_ack); end
    checks++; if (bus.ReadDataM !== 32'hAAAA_0000) begin errs++; $display("FAIL idle_load got=%h exp=AAAA0000", bus.ReadDataM); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa [3];
    logic [31:0] wd [3];
    wa = '{32'd1, 32'd2, 32'd1};
    wd = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, wa[i], wd[i], 1'b0);
      checks++; if ({bus.mem_we, bus.StallM} !== 2'b00) begin errs++; $display("FAIL b2b_store%0d we/stall got=%b exp=00", i, {bus.mem_we, bus.StallM}); end
      tick();
    end
    drive(1'b0, 1'b1, 32'd1, 32'd0, 1'b0);
    checks++; if (bus.ReadDataM !== 32'h33) begin errs++; $display("FAIL b2b_fwd got=%h exp=33", bus.ReadDataM); end
    checks++; if (bus.mem_we !== 1'b0) begin errs++; $display("FAIL b2b_load_we got=%b exp=0", bus.mem_we); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, wa[i], wd[i]}) begin
        errs++; $display("FAIL b2b_drain%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, wa[i], wd[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checks++; if (bus.fence_ack !== 1'b1) begin errs++; $display("FAIL b2b_ack got=%b exp=1", bus.fence_ack); end
    tick();
  endtask

  task automatic test_full();
    logic [31:0] oa [4];
    oa = '{32'd4, 32'd5, 32'd6, 32'd9};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'd3 + 32'(i), 32'h30 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'd9, 32'h99, 1'b0);
    checks++; if ({bus.StallM, bus.mem_we} !== 2'b11) begin errs++; $display("FAIL full_stall stall/we got=%b exp=11", {bus.StallM, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 32'd3) begin errs++; $display("FAIL full_drain_addr got=%h exp=3", bus.mem_addr); end
    tick();
    drive(1'b1, 1'b0, 32'd9, 32'h99, 1'b0);
    checks++; if ({bus.StallM, bus.mem_we} !== 2'b00) begin errs++; $display("FAIL full_retry stall/we got=%b exp=00", {bus.StallM, bus.mem_we}); end
    tick();
    drive(1'b0, 1'b1, 32'd9, 32'd0, 1'b0);
    checks++; if (bus.ReadDataM !== 32'h99) begin errs++; $display("FAIL full_fwd got=%h exp=99", bus.ReadDataM); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({bus.fence_ack, bus.mem_we, bus.mem_addr} !== {2'b01, oa[i]}) begin
        errs++; $display("FAIL full_drain%0d got ack=%b we=%b a=%h exp ack=0 we=1 a=%h", i, bus.fence_ack, bus.mem_we, bus.mem_addr, oa[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checks++; if (bus.fence_ack !== 1'b1) begin errs++; $display("FAIL full_empty_ack got=%b exp=1", bus.fence_ack); end
    tick();
  endtask

  task automatic test_alternating();
    int          phase = 0;
    int          done  = 0;
    logic        hold  = 1'b0;
    logic [31:0] sa = 32'd0;
    logic [31:0] sd = 32'd0;
    for (int c = 0; c < 40 && done < 20; c++) begin
      if (phase == 0) begin
        if (!hold) begin
          sa = $urandom_range(0, 7);
          sd = $urandom;
        end
        drive(1'b1, 1'b0, sa, sd, 1'b0);
      end else begin
        drive(1'b0, 1'b1, $urandom_range(0, 7), 32'd0, 1'b0);
      end
      checks++;
      if ({bus.mem_we, bus.StallM} !== {e_we, e_stall}) begin
        errs++; $display("FAIL alt_c%0d we/stall got=%b exp=%b", c, {bus.mem_we, bus.StallM}, {e_we, e_stall});
      end
      if (e_chk_rd) begin
        checks++;
        if (bus.ReadDataM !== e_rdata) begin errs++; $display("FAIL alt_load_c%0d got=%h exp=%h", c, bus.ReadDataM, e_rdata); end
      end
      hold = e_stall;
      if (!e_stall) begin
        phase = 1 - phase;
        done++;
      end
      tick();
    end
  endtask

  task automatic test_drain_order();
    for (int c = 0; c < 3 * DEPTH && q.size() > 0; c++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, e_addr, e_wdata}) begin
        errs++; $display("FAIL drain_c%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_addr, e_wdata);
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checks++; if ({bus.fence_ack, bus.mem_we} !== 2'b10) begin errs++; $display("FAIL drain_done ack/we got=%b exp=10", {bus.fence_ack, bus.mem_we}); end
    tick();
  endtask

  task automatic test_fence();
    drive(1'b1, 1'b0, 32'd7, 32'h77, 1'b0); tick();
    drive(1'b1, 1'b0, 32'd8, 32'h88, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd10, 32'hAA, 1'b1);
      checks++;
      if ({bus.StallM, bus.fence_ack, bus.mem_we, bus.mem_addr} !== {3'b101, (i == 0) ? 32'd7 : 32'd8}) begin
        errs++; $display("FAIL fence_drain%0d got stall=%b ack=%b we=%b a=%h exp stall=1 ack=0 we=1 a=%0d", i, bus.StallM, bus.fence_ack, bus.mem_we, bus.mem_addr, (i == 0) ? 7 : 8);
      end
      tick();
    end
    drive(1'b1, 1'b0, 32'd10, 32'hAA, 1'b1);
    checks++; if ({bus.StallM, bus.fence_ack, bus.mem_we} !== 3'b010) begin errs++; $display("FAIL fence_release stall/ack/we got=%b exp=010", {bus.StallM, bus.fence_ack, bus.mem_we}); end
    tick();
    drive(1'b0, 1'b1, 32'd10, 32'd0, 1'b0);
    checks++; if (bus.ReadDataM !== 32'hAA) begin errs++; $display("FAIL fence_store_fwd got=%h exp=AA", bus.ReadDataM); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd12 + 32'(i), 32'h1200 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    checks++; if (bus.mem_we !== 1'b1) begin errs++; $display("FAIL mid_drain_we got=%b exp=1", bus.mem_we); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.mem_we, bus.fence_ack, bus.StallM} !== 3'b010) begin errs++; $display("FAIL mid_rst we/ack/stall got=%b exp=010", {bus.mem_we, bus.fence_ack, bus.StallM}); end
    q.delete();
    act = 0;
    #1 rst = 1'b1;
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b1, 32'd13, 32'd0, 1'b0);
    checks++; if (bus.ReadDataM !== 32'hD0D0_000D) begin errs++; $display("FAIL mid_load got=%h exp=D0D0000D", bus.ReadDataM); end
    tick();
  endtask

  task automatic test_random();
    int          op = 0;
    logic        f = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] d = 32'd0;
    for (int c = 0; c < 200; c++) begin
      if (!hold) begin
        op = $urandom_range(0, 3);
        a  = $urandom_range(0, 15);
        d  = $urandom;
        f  = ($urandom_range(0, 9) == 0);
      end
      drive(op == 1, op == 2, a, d, f);
      checks++;
      if ({bus.mem_we, bus.StallM, bus.fence_ack} !== {e_we, e_stall, e_ack}) begin
        errs++; $display("FAIL rnd_c%0d we/stall/ack got=%b exp=%b", c, {bus.mem_we, bus.StallM, bus.fence_ack}, {e_we, e_stall, e_ack});
      end
      if (e_we) begin
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {e_addr, e_wdata}) begin
          errs++; $display("FAIL rnd_wr_c%0d got a=%h d=%h exp a=%h d=%h", c, bus.mem_addr, bus.mem_wdata, e_addr, e_wdata);
        end
      end
      if (e_chk_rd) begin
        checks++;
        if (bus.ReadDataM !== e_rdata) begin errs++; $display("FAIL rnd_load_c%0d got=%h exp=%h", c, bus.ReadDataM, e_rdata); end
      end
      hold = e_stall;
      tick();
    end
  endtask

  initial begin
    bus.MemWriteM  = 1'b0;
    bus.MemReadM   = 1'b0;
    bus.AddrM      = 32'd0;
    bus.WriteDataM = 32'd0;
    bus.fence_req  = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 5) ? 32'hAAAA_0000 : (32'hD0D0_0000 | 32'(i));
    test_reset();
    test_back_to_back();
    test_full();
    test_alternating();
    test_drain_order();
    test_fence();
    test_reset_mid();
    test_random();
    test_drain_order();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
